// File: rtl/axi_fifo_pkt_if.sv
// AXI-Stream beat bundle (tvalid/tready/tdata/tlast) shared by both sides of the FIFO.
interface axi_fifo_pkt_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_fifo_pkt.sv
// AXI-Stream FIFO with tlast storage, registered fill level/threshold flags and
// optional store-and-forward gating so downstream never sees a partial packet.
module axi_fifo_pkt #(
  parameter int    DATA_WIDTH          = 32,
  parameter int    ADDR_WIDTH          = 8,
  parameter int    ALMOST_FULL_THRESH  = 240,
  parameter int    ALMOST_EMPTY_THRESH = 4,
  parameter int    PACKET_MODE         = 0,
  parameter string RAM_STYLE           = "distributed"
) (
  input  logic                  clk,
  input  logic                  sync_reset_n,
  axi_fifo_pkt_if.slave         s_axis,
  axi_fifo_pkt_if.master        m_axis,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AF_T = PW'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_T = PW'(ALMOST_EMPTY_THRESH);

  logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_q, rd_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_n, rd_ptr_n, count_n;
  logic                full, wr_en, rd_en, gate, d1_load, wr_last, rd_last;
  logic                d0_v, d1_v, open_q, oversize;
  logic [DATA_WIDTH:0] d0, d1, ram_rd;

  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign wr_en = s_axis.tvalid && !full;
  assign s_axis.tready = !full;

  // The read side sees writes one cycle late, so it never addresses the word being written.
  assign gate    = (PACKET_MODE == 0) || (open_q && ((pkt_count != '0) || oversize));
  assign rd_en   = (rd_ptr != wr_ptr_q) && gate && (!(d0_v && d1_v) || m_axis.tready);
  assign d1_load = m_axis.tready || !d1_v;
  assign wr_last = wr_en && s_axis.tlast;
  assign rd_last = rd_en && ram_rd[DATA_WIDTH];

  assign wr_ptr_n = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_en};
  assign rd_ptr_n = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_en};
  assign count_n  = wr_ptr_n - rd_ptr_n;

  assign m_axis.tvalid = d1_v;
  assign m_axis.tdata  = d1[DATA_WIDTH-1:0];
  assign m_axis.tlast  = d1[DATA_WIDTH];

  if (RAM_STYLE == "block") begin : g_ram
    (* ram_style = "block" *) logic [DATA_WIDTH:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tdata};
    end
    assign ram_rd = mem[rd_ptr[ADDR_WIDTH-1:0]];
  end else begin : g_ram
    (* ram_style = "distributed" *) logic [DATA_WIDTH:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tdata};
    end
    assign ram_rd = mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      wr_ptr       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      almost_full  <= ('0 >= AF_T);
      almost_empty <= 1'b1;
      d0           <= '0;
      d1           <= '0;
      d0_v         <= 1'b0;
      d1_v         <= 1'b0;
      pkt_count    <= '0;
      oversize     <= 1'b0;
      open_q       <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      wr_ptr_q     <= wr_ptr;
      rd_ptr       <= rd_ptr_n;
      data_count   <= count_n;
      almost_full  <= (count_n >= AF_T);
      almost_empty <= (count_n <= AE_T);

      if (rd_en) d0 <= ram_rd;
      d0_v <= rd_en || (d0_v && !d1_load);
      if (d1_load) begin
        d1_v <= d0_v;
        if (d0_v) d1 <= d0;
      end

      // Override lets a packet longer than the RAM drain cut-through instead of deadlocking.
      if (PACKET_MODE != 0) begin
        case ({wr_last, rd_last})
          2'b10:   pkt_count <= pkt_count + 1'b1;
          2'b01:   pkt_count <= pkt_count - 1'b1;
          default: pkt_count <= pkt_count;
        endcase
        if (rd_last)
          oversize <= 1'b0;
        else if (full && (pkt_count == '0))
          oversize <= 1'b1;
        open_q <= (pkt_count != '0) || oversize;
      end
    end
  end

endmodule

// File: tb/tb_axi_fifo_pkt.sv
// Scoreboard bench: a cut-through and a packet-mode FIFO (both 16 deep) share one
// stimulus path selected by 'mode'; accepted beats are queued and matched at the output.
module tb_axi_fifo_pkt;

  logic        clk = 1'b0;
  logic        sync_reset_n = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic [4:0]  cnt_ct, cnt_pk, pkt_ct, pkt_pk;
  logic        af_ct, ae_ct, af_pk, ae_pk;

  logic        obs_s_ready, obs_valid, obs_last, obs_af, obs_ae;
  logic [31:0] obs_data;
  logic [4:0]  obs_count, obs_pkt;

  int          vectors = 0;
  int          miscompares = 0;
  int          out_cnt = 0;
  logic        wr_acc = 1'b0;
  logic [32:0] sb[$];

  axi_fifo_pkt_if #(.DATA_WIDTH(32)) s_ct ();
  axi_fifo_pkt_if #(.DATA_WIDTH(32)) m_ct ();
  axi_fifo_pkt_if #(.DATA_WIDTH(32)) s_pk ();
  axi_fifo_pkt_if #(.DATA_WIDTH(32)) m_pk ();

  axi_fifo_pkt #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ALMOST_FULL_THRESH(12),
                 .ALMOST_EMPTY_THRESH(4), .PACKET_MODE(0)) dut_ct (
    .clk(clk), .sync_reset_n(sync_reset_n), .s_axis(s_ct.slave), .m_axis(m_ct.master),
    .data_count(cnt_ct), .almost_full(af_ct), .almost_empty(ae_ct), .pkt_count(pkt_ct));

  axi_fifo_pkt #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ALMOST_FULL_THRESH(12),
                 .ALMOST_EMPTY_THRESH(4), .PACKET_MODE(1)) dut_pk (
    .clk(clk), .sync_reset_n(sync_reset_n), .s_axis(s_pk.slave), .m_axis(m_pk.master),
    .data_count(cnt_pk), .almost_full(af_pk), .almost_empty(ae_pk), .pkt_count(pkt_pk));

  assign s_ct.tvalid = in_valid && !mode;
  assign s_ct.tdata  = in_data;
  assign s_ct.tlast  = in_last;
  assign m_ct.tready = out_ready && !mode;
  assign s_pk.tvalid = in_valid && mode;
  assign s_pk.tdata  = in_data;
  assign s_pk.tlast  = in_last;
  assign m_pk.tready = out_ready && mode;

  assign obs_s_ready = mode ? s_pk.tready : s_ct.tready;
  assign obs_valid   = mode ? m_pk.tvalid : m_ct.tvalid;
  assign obs_data    = mode ? m_pk.tdata  : m_ct.tdata;
  assign obs_last    = mode ? m_pk.tlast  : m_ct.tlast;
  assign obs_count   = mode ? cnt_pk : cnt_ct;
  assign obs_af      = mode ? af_pk  : af_ct;
  assign obs_ae      = mode ? ae_pk  : ae_ct;
  assign obs_pkt     = mode ? pkt_pk : pkt_ct;

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle: inputs held across the edge, handshakes sampled on the falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l, input logic r);
    logic [32:0] exp_beat;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(negedge clk);
    wr_acc = in_valid && obs_s_ready;
    if (obs_valid && out_ready) begin
      out_cnt++;
      if (sb.size() == 0)
        checkOutput("unexpected_beat", 64'd1, 64'd0);
      else begin
        exp_beat = sb.pop_front();
        checkOutput("beat", {31'd0, obs_last, obs_data}, {31'd0, exp_beat});
      end
    end
    if (wr_acc) sb.push_back({in_last, in_data});
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    sync_reset_n = 1'b0;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sync_reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic drainAll(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int sent, acc, base, cyc;
    logic ovr_seen;

    // Reset state, cut-through instance
    mode = 1'b0;
    doReset(2);
    checkOutput("rst_s_ready", 64'(obs_s_ready), 64'd1);
    checkOutput("rst_m_valid", 64'(obs_valid), 64'd0);
    checkOutput("rst_m_data", 64'(obs_data), 64'd0);
    checkOutput("rst_m_last", 64'(obs_last), 64'd0);
    checkOutput("rst_count", 64'(obs_count), 64'd0);
    checkOutput("rst_af", 64'(obs_af), 64'd0);
    checkOutput("rst_ae", 64'(obs_ae), 64'd1);
    checkOutput("rst_pkt", 64'(obs_pkt), 64'd0);

    // Single-beat latency: write at edge N, valid after N+3
    applyStimulus(1'b1, 32'hA5, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("lat_n2_valid", 64'(obs_valid), 64'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("lat_n3_valid", 64'(obs_valid), 64'd1);
    checkOutput("lat_n3_data", 64'(obs_data), 64'hA5);
    drainAll("lat_drain", 10);

    // Random-handshake stream of 1000 words
    out_cnt = 0;
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      applyStimulus(($urandom % 4) != 0, 32'(sent), (sent % 5) == 4, ($urandom % 4) != 0);
      if (wr_acc) sent++;
      cyc++;
    end
    checkOutput("stream_sent", 64'(sent), 64'd1000);
    drainAll("stream_drain", 200);
    checkOutput("stream_out", 64'(out_cnt), 64'd1000);
    checkOutput("stream_pkt0", 64'(obs_pkt), 64'd0);

    // Fill with downstream stalled, then drain and watch thresholds
    doReset(1);
    acc = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 32'h1000 + 32'(acc), 1'b0, 1'b0);
      if (wr_acc) acc++;
    end
    checkOutput("fill_accepted", 64'(acc), 64'd18);
    checkOutput("fill_s_ready", 64'(obs_s_ready), 64'd0);
    checkOutput("fill_count", 64'(obs_count), 64'd16);
    checkOutput("fill_af", 64'(obs_af), 64'd1);
    checkOutput("fill_ae", 64'(obs_ae), 64'd0);
    out_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
      if (k <= 16) begin
        checkOutput("drain_count", 64'(obs_count), 64'(16 - k));
        checkOutput("drain_af", 64'(obs_af), 64'((16 - k) >= 12));
        checkOutput("drain_ae", 64'(obs_ae), 64'((16 - k) <= 4));
      end
    end
    checkOutput("drain_out", 64'(out_cnt), 64'd18);
    checkOutput("drain_sb", 64'(sb.size()), 64'd0);

    // Reset with data resident; the next word written must be the first out
    doReset(1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("mid_count7", 64'(obs_count), 64'd7);
    doReset(1);
    checkOutput("mid_rst_count", 64'(obs_count), 64'd0);
    checkOutput("mid_rst_valid", 64'(obs_valid), 64'd0);
    out_cnt = 0;
    applyStimulus(1'b1, 32'h1234, 1'b0, 1'b1);
    drainAll("mid_drain", 10);
    checkOutput("mid_out", 64'(out_cnt), 64'd1);

    // Packet mode: output held until tlast arrives
    mode = 1'b1;
    doReset(2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("pkt_hold_valid", 64'(obs_valid), 64'd0);
    checkOutput("pkt_hold_count", 64'(obs_pkt), 64'd0);
    out_cnt = 0;
    applyStimulus(1'b1, 32'h205, 1'b1, 1'b1);
    checkOutput("pkt_count1", 64'(obs_pkt), 64'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("pkt_n2_valid", 64'(obs_valid), 64'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("pkt_n3_valid", 64'(obs_valid), 64'd1);
    drainAll("pkt_drain", 20);
    checkOutput("pkt_out", 64'(out_cnt), 64'd6);
    checkOutput("pkt_count0", 64'(obs_pkt), 64'd0);

    // Packet mode: 40-beat packet through a 16-deep RAM
    doReset(1);
    out_cnt = 0;
    sent = 0;
    ovr_seen = 1'b0;
    base = 32'h300;
    for (cyc = 0; cyc < 400 && (sent < 40 || sb.size() != 0); cyc++) begin
      applyStimulus(sent < 40, 32'(base + sent), sent == 39, 1'b1);
      if (wr_acc) sent++;
      if (dut_pk.oversize) ovr_seen = 1'b1;
    end
    checkOutput("ovr_sent", 64'(sent), 64'd40);
    checkOutput("ovr_out", 64'(out_cnt), 64'd40);
    checkOutput("ovr_seen", 64'(ovr_seen), 64'd1);
    checkOutput("ovr_cleared", 64'(dut_pk.oversize), 64'd0);
    checkOutput("ovr_pkt0", 64'(obs_pkt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
